// File: rtl/ltc_pkg.sv
// Shared LTC definitions: sync word, frame geometry and framer state.
package ltc_pkg;
   localparam logic [15:0] SYNC_WORD  = 16'hBFFC;
   localparam int          FRAME_BITS = 80;
   localparam int          DATA_BITS  = 64;

   typedef enum logic {HUNT, LOCKED} ltc_state_e;
endpackage

// File: rtl/ltc_bmc_dec.sv
// Biphase-mark decoder: synchronizes the line, times edge intervals against an
// adaptive short/long threshold and emits decoded bits.
module ltc_bmc_dec #(
   parameter int CLK_F     = 50000000,
   parameter int NOM_BIT_F = 2400,
   parameter int CNT_W     = 20,
   parameter int TIMEOUT   = 2*CLK_F/NOM_BIT_F
) (
   input  logic clk_i,
   input  logic reset,
   input  logic ltc_i,
   output logic bit_o,
   output logic bit_valid_o,
   output logic viol_o,
   output logic timeout_o
);
   localparam int               THR0     = (3*CLK_F)/(4*NOM_BIT_F);
   localparam logic [CNT_W-1:0] THR_INIT = CNT_W'(THR0);
   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

   logic [2:0]       sync_q;
   logic [CNT_W-1:0] cnt, thr, p1;
   logic             half;
   logic             edge_w, take, is_long;
   logic [CNT_W+1:0] cnt_x, pair_sum, long_x3, pair_x3;

   assign edge_w   = sync_q[1] ^ sync_q[2];
   // Edges closer than a quarter threshold to the last accepted edge are noise
   assign take     = edge_w && (cnt >= (thr >> 2));
   assign is_long  = cnt >= thr;
   assign cnt_x    = {2'b00, cnt};
   assign pair_sum = {2'b00, p1} + cnt_x;
   assign long_x3  = cnt_x + (cnt_x << 1);
   assign pair_x3  = pair_sum + (pair_sum << 1);

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         cnt         <= '0;
         thr         <= THR_INIT;
         p1          <= '0;
         half        <= 1'b0;
         bit_o       <= 1'b0;
         bit_valid_o <= 1'b0;
         viol_o      <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[1:0], ltc_i};
         bit_valid_o <= 1'b0;
         viol_o      <= 1'b0;
         timeout_o   <= 1'b0;
         if (take) begin
            cnt <= CNT_W'(1);
            if (is_long) begin
               if (half) begin
                  viol_o <= 1'b1;
                  half   <= 1'b0;
               end else begin
                  bit_o       <= 1'b0;
                  bit_valid_o <= 1'b1;
                  thr         <= long_x3[CNT_W+1:2];
               end
            end else if (half) begin
               bit_o       <= 1'b1;
               bit_valid_o <= 1'b1;
               half        <= 1'b0;
               thr         <= pair_x3[CNT_W+1:2];
            end else begin
               half <= 1'b1;
               p1   <= cnt;
            end
         end else begin
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            if (cnt == TMO) begin
               timeout_o <= 1'b1;
               half      <= 1'b0;
               thr       <= THR_INIT;
            end
         end
      end
   end
endmodule

// File: rtl/ltc_rx.sv
// LTC receiver: decoded bits feed an 80-bit shift register; a HUNT/LOCKED
// framer aligns on the sync word and presents the 64 data bits.
module ltc_rx
   import ltc_pkg::*;
#(
   parameter int CLK_F     = 50000000,
   parameter int NOM_BIT_F = 2400,
   parameter int CNT_W     = 20,
   parameter int TIMEOUT   = 2*CLK_F/NOM_BIT_F
) (
   input  logic                 clk_i,
   input  logic                 reset,
   input  logic                 ltc_i,
   output logic                 bit_o,
   output logic                 bit_valid_o,
   output logic [DATA_BITS-1:0] frame_o,
   output logic                 frame_valid_o,
   output logic                 locked_o,
   output logic                 err_o
);
   localparam logic [6:0] FB = 7'(FRAME_BITS);

   logic                  viol, timeout, chk_q, sync_hit;
   logic [FRAME_BITS-1:0] sr;
   logic [6:0]            bit_cnt;
   ltc_state_e            state;

   ltc_bmc_dec #(
      .CLK_F(CLK_F), .NOM_BIT_F(NOM_BIT_F), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) u_dec (
      .clk_i(clk_i), .reset(reset), .ltc_i(ltc_i),
      .bit_o(bit_o), .bit_valid_o(bit_valid_o),
      .viol_o(viol), .timeout_o(timeout)
   );

   assign sync_hit = sr[FRAME_BITS-1:DATA_BITS] == SYNC_WORD;

   // Framing decisions run one cycle after a bit lands so sr and bit_cnt are current
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         sr            <= '0;
         bit_cnt       <= '0;
         chk_q         <= 1'b0;
         state         <= HUNT;
         frame_o       <= '0;
         frame_valid_o <= 1'b0;
         locked_o      <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         frame_valid_o <= 1'b0;
         err_o         <= viol | timeout;
         chk_q         <= bit_valid_o;
         if (bit_valid_o) begin
            sr <= {bit_o, sr[FRAME_BITS-1:1]};
            if (bit_cnt < FB) bit_cnt <= bit_cnt + 7'd1;
         end
         if (timeout) begin
            state    <= HUNT;
            locked_o <= 1'b0;
            bit_cnt  <= '0;
         end else if (viol) begin
            bit_cnt <= '0;
         end else if (chk_q) begin
            case (state)
               HUNT: if (sync_hit && bit_cnt >= FB) begin
                  state         <= LOCKED;
                  locked_o      <= 1'b1;
                  frame_o       <= sr[DATA_BITS-1:0];
                  frame_valid_o <= 1'b1;
                  bit_cnt       <= '0;
               end
               LOCKED: if (bit_cnt == FB) begin
                  if (sync_hit) begin
                     frame_o       <= sr[DATA_BITS-1:0];
                     frame_valid_o <= 1'b1;
                     bit_cnt       <= '0;
                  end else begin
                     state    <= HUNT;
                     locked_o <= 1'b0;
                     err_o    <= 1'b1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ltc_rx.sv
// Directed bench for ltc_rx at a scaled clock: 32-cycle nominal bits, 16-cycle halves.
module tb_ltc_rx;
   localparam logic [63:0] DATA    = 64'h0123456789ABCDEF;
   localparam logic [15:0] TX_SYNC = 16'b0011111111111101; // leftmost sent first

   logic        clk_i = 1'b0;
   logic        reset, ltc_i;
   logic        bit_o, bit_valid_o, frame_valid_o, locked_o, err_o;
   logic [63:0] frame_o;

   int          tests = 0, fails = 0, err_cnt = 0, frames_seen = 0;
   int          e0, f0;
   logic [63:0] exp_q[$];

   ltc_rx #(.CLK_F(64000), .NOM_BIT_F(2000), .CNT_W(12)) dut (
      .clk_i(clk_i), .reset(reset), .ltc_i(ltc_i),
      .bit_o(bit_o), .bit_valid_o(bit_valid_o),
      .frame_o(frame_o), .frame_valid_o(frame_valid_o),
      .locked_o(locked_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (err_o) err_cnt++;
      if (frame_valid_o) begin
         frames_seen++;
         if (exp_q.size() == 0) chk("frame_unexpected", 64'(exp_q.size()), 64'd1);
         else chk("frame_data", frame_o, exp_q.pop_front());
      end
   end

   function automatic logic frame_bit(input int k);
      logic [63:0] d;
      logic [15:0] s;
      d = DATA;
      s = TX_SYNC;
      if (k < 64) return d[k];
      return s[15-(k-64)];
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_bit(input logic b, input int h);
      ltc_i = ~ltc_i;
      wait_cyc(h);
      if (b) ltc_i = ~ltc_i;
      wait_cyc(h);
   endtask

   task automatic send_range(input int lo, input int hi, input int h);
      for (int k = lo; k <= hi; k++) send_bit(frame_bit(k), h);
   endtask

   initial begin
      reset = 1'b1;
      ltc_i = 1'b0;
      wait_cyc(3);
      chk("rst_frame", frame_o, 64'h0);
      chk("rst_locked", 64'(locked_o), 64'h0);
      chk("rst_fvalid", 64'(frame_valid_o), 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      chk("rst_bvalid", 64'(bit_valid_o), 64'h0);
      chk("rst_thr", 64'(dut.u_dec.thr), 64'd24);
      reset = 1'b0;
      wait_cyc(30);

      // clean stream, three frames
      e0 = err_cnt;
      exp_q.push_back(DATA); send_range(0, 79, 16);
      exp_q.push_back(DATA); send_range(0, 79, 16);
      chk("clean_locked", 64'(locked_o), 64'h1);
      exp_q.push_back(DATA); send_range(0, 79, 16);
      chk("clean_err", 64'(err_cnt - e0), 64'h0);

      // rate step: 26-cycle bits, then 34-cycle bits
      exp_q.push_back(DATA); send_range(0, 79, 13);
      exp_q.push_back(DATA); send_range(0, 79, 13);
      chk("fast_thr", 64'(dut.u_dec.thr), 64'd19);
      exp_q.push_back(DATA); send_range(0, 2, 17);
      chk("slow_thr", 64'(dut.u_dec.thr), 64'd25);
      send_range(3, 79, 17);
      exp_q.push_back(DATA); send_range(0, 79, 17);
      chk("rate_err", 64'(err_cnt - e0), 64'h0);

      // short glitch right after the edge of a zero bit
      exp_q.push_back(DATA); send_range(0, 3, 16);
      ltc_i = ~ltc_i; wait_cyc(1);
      ltc_i = ~ltc_i; wait_cyc(2);
      ltc_i = ~ltc_i; wait_cyc(29);
      send_range(5, 79, 16);
      chk("glitch_err", 64'(err_cnt - e0), 64'h0);

      // SHORT then LONG in bit 30: violation, then lost frame
      e0 = err_cnt;
      send_range(0, 29, 16);
      f0 = frames_seen;
      ltc_i = ~ltc_i; wait_cyc(16);
      ltc_i = ~ltc_i; wait_cyc(32);
      send_range(31, 79, 16);
      send_range(0, 49, 16);
      chk("viol_locked", 64'(locked_o), 64'h0);
      chk("viol_err", 64'(err_cnt - e0), 64'd2);
      chk("viol_noframe", 64'(frames_seen - f0), 64'h0);
      exp_q.push_back(DATA);
      send_range(50, 79, 16);

      // line goes static past the timeout
      exp_q.push_back(DATA); send_range(0, 79, 17);
      e0 = err_cnt;
      ltc_i = ~ltc_i;
      wait_cyc(74);
      chk("tmo_err", 64'(err_cnt - e0), 64'd1);
      chk("tmo_locked", 64'(locked_o), 64'h0);
      chk("tmo_thr", 64'(dut.u_dec.thr), 64'd24);
      send_bit(1'b1, 16);
      exp_q.push_back(DATA); send_range(0, 79, 16);

      // one-cycle asynchronous reset inside a frame
      fork
         send_range(0, 79, 16);
         begin
            wait_cyc(650);
            #2 reset = 1'b1;
            #1;
            chk("mrst_frame", frame_o, 64'h0);
            chk("mrst_locked", 64'(locked_o), 64'h0);
            chk("mrst_err", 64'(err_o), 64'h0);
            chk("mrst_bit", 64'(bit_o), 64'h0);
            chk("mrst_fvalid", 64'(frame_valid_o), 64'h0);
            @(negedge clk_i);
            reset = 1'b0;
            f0 = frames_seen;
         end
      join
      send_range(0, 1, 16);
      chk("mrst_noframe", 64'(frames_seen - f0), 64'h0);
      exp_q.push_back(DATA);
      send_range(2, 79, 16);
      ltc_i = ~ltc_i;
      wait_cyc(40);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
